// File: rtl/axis_spi_slave.sv
// SPI slave endpoint: oversamples the SPI pins on clk_i, delivers received words on an
// AXI-Stream master port and serialises AXI-Stream slave words back onto MISO.
module axis_spi_slave #(
    parameter int unsigned SPI_MODE   = 1,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spi_clk_i,
    input  logic                  spi_cs_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    output logic                  m_axis_tlast_o,
    input  logic                  m_axis_tready_i,
    output logic                  underrun_o,
    output logic                  overrun_o,
    output logic                  frame_err_o
);

    localparam int unsigned    CNT_W    = $clog2(DATA_WIDTH);
    localparam logic           CPOL     = 1'(SPI_MODE >> 1);
    localparam logic           CPHA     = 1'(SPI_MODE);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             sclk_q, cs_q;
    logic [1:0]             mosi_q;
    logic [1:0]             settle_q;
    logic                   arm_q, arm_d;
    logic                   sample_q, shift_q, cs_fall_q, cs_rise_q;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  rx_q, rx_d, pend_q, pend_d, tx_q, tx_d, m_data_q, m_data_d;
    logic                   pend_vld_q, pend_vld_d;
    logic                   miso_q, miso_d, load_q, load_d;
    logic                   m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic                   underrun_q, underrun_d, overrun_q, overrun_d, ferr_q, ferr_d;

    logic                   lead_c, trail_c;
    logic                   present, present_last;
    logic [DATA_WIDTH-1:0]  word;

    // Edges seen on the synchronised SCLK relative to its idle level.
    assign lead_c  = (sclk_q[2] == CPOL) && (sclk_q[1] != CPOL);
    assign trail_c = (sclk_q[2] != CPOL) && (sclk_q[1] == CPOL);

    // A CS fall is only trusted once CS has been seen high after reset, so a
    // frame interrupted by reset is never picked up half way.
    always_comb begin
        state_d      = state_q;
        arm_d        = arm_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        load_d       = 1'b0;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        underrun_d   = 1'b0;
        overrun_d    = 1'b0;
        ferr_d       = 1'b0;
        present      = 1'b0;
        present_last = 1'b0;
        word         = '0;

        if (settle_q[1] && cs_q[1]) arm_d = 1'b1;
        if (m_valid_q && m_axis_tready_i) m_valid_d = 1'b0;

        if (load_q) begin
            if (s_axis_tvalid_i) begin
                word = s_axis_tdata_i;
            end else begin
                underrun_d = 1'b1;
            end
            if (CPHA) begin
                tx_d = word;
            end else begin
                miso_d = word[DATA_WIDTH-1];
                tx_d   = {word[DATA_WIDTH-2:0], 1'b0};
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall_q && arm_q) begin
                    state_d    = ST_ACTIVE;
                    load_d     = 1'b1;
                    bit_cnt_d  = '0;
                    rx_d       = '0;
                    pend_vld_d = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_q) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    if (bit_cnt_q != '0) ferr_d = 1'b1;
                    if (pend_vld_q) begin
                        present      = 1'b1;
                        present_last = 1'b1;
                        pend_vld_d   = 1'b0;
                    end
                end else begin
                    if (sample_q) begin
                        if (pend_vld_q) begin
                            present    = 1'b1;
                            pend_vld_d = 1'b0;
                        end
                        rx_d = {rx_q[DATA_WIDTH-2:0], mosi_q[1]};
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d  = '0;
                            pend_d     = rx_d;
                            pend_vld_d = 1'b1;
                            load_d     = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    // CPHA=0 already drove the MSB at load time; skip the shift edge between words.
                    if (shift_q && (CPHA || (bit_cnt_q != '0))) begin
                        miso_d = tx_q[DATA_WIDTH-1];
                        tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (present) begin
            if (m_valid_q && !m_axis_tready_i) begin
                overrun_d = 1'b1;
            end else begin
                m_data_d  = pend_q;
                m_last_d  = present_last;
                m_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            sclk_q     <= {3{CPOL}};
            cs_q       <= 3'b111;
            mosi_q     <= '0;
            settle_q   <= '0;
            arm_q      <= 1'b0;
            sample_q   <= 1'b0;
            shift_q    <= 1'b0;
            cs_fall_q  <= 1'b0;
            cs_rise_q  <= 1'b0;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            tx_q       <= '0;
            miso_q     <= 1'b0;
            load_q     <= 1'b0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sclk_q     <= {sclk_q[1:0], spi_clk_i};
            cs_q       <= {cs_q[1:0], spi_cs_i};
            mosi_q     <= {mosi_q[0], spi_mosi_i};
            settle_q   <= {settle_q[0], 1'b1};
            arm_q      <= arm_d;
            sample_q   <= CPHA ? trail_c : lead_c;
            shift_q    <= CPHA ? lead_c : trail_c;
            cs_fall_q  <= cs_q[2] & ~cs_q[1];
            cs_rise_q  <= ~cs_q[2] & cs_q[1];
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
            load_q     <= load_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
        end
    end

    assign spi_miso_o      = miso_q;
    assign s_axis_tready_o = load_q;
    assign m_axis_tdata_o  = m_data_q;
    assign m_axis_tvalid_o = m_valid_q;
    assign m_axis_tlast_o  = m_last_q;
    assign underrun_o      = underrun_q;
    assign overrun_o       = overrun_q;
    assign frame_err_o     = ferr_q;

endmodule

// File: tb/tb_axis_spi_slave.sv
// Directed bench for axis_spi_slave: one instance per SPI mode, bit-banged SPI master,
// stream monitor counting beats and flag pulses.
module tb_axis_spi_slave;

    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sclk = 4'b1100, cs = 4'hF, mosi = 4'h0, miso;
    logic [3:0] s_tvalid = 4'hF, s_tready, m_tvalid, m_tlast, m_tready = 4'hF;
    logic [3:0] underrun, overrun, frame_err;
    logic [7:0] s_tdata [4] = '{default: 8'h00};
    logic [7:0] m_tdata [4];

    int errors = 0;
    int checks = 0;
    int n_under [4] = '{default: 0};
    int n_over  [4] = '{default: 0};
    int n_ferr  [4] = '{default: 0};
    int n_rx    [4] = '{default: 0};
    int n_shs   [4] = '{default: 0};
    logic [7:0] rx_data [4][16];
    logic       rx_last [4][16];
    logic [7:0] f_mosi [5];
    logic [7:0] f_tx   [5] = '{default: 8'h00};
    logic [7:0] f_miso [5];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        axis_spi_slave #(.SPI_MODE(g), .DATA_WIDTH(8)) u_dut (
            .clk_i           (clk),
            .rst_i           (rst),
            .spi_clk_i       (sclk[g]),
            .spi_cs_i        (cs[g]),
            .spi_mosi_i      (mosi[g]),
            .spi_miso_o      (miso[g]),
            .s_axis_tdata_i  (s_tdata[g]),
            .s_axis_tvalid_i (s_tvalid[g]),
            .s_axis_tready_o (s_tready[g]),
            .m_axis_tdata_o  (m_tdata[g]),
            .m_axis_tvalid_o (m_tvalid[g]),
            .m_axis_tlast_o  (m_tlast[g]),
            .m_axis_tready_i (m_tready[g]),
            .underrun_o      (underrun[g]),
            .overrun_o       (overrun[g]),
            .frame_err_o     (frame_err[g])
        );
    end

    // Stream/flag monitor, sampled mid-cycle after the bench has driven its inputs.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                for (int g = 0; g < 4; g++) begin
                    if (underrun[g])  n_under[g] = n_under[g] + 1;
                    if (overrun[g])   n_over[g]  = n_over[g] + 1;
                    if (frame_err[g]) n_ferr[g]  = n_ferr[g] + 1;
                    if (s_tready[g] && s_tvalid[g]) n_shs[g] = n_shs[g] + 1;
                    if (m_tvalid[g] && m_tready[g]) begin
                        rx_data[g][n_rx[g] % 16] = m_tdata[g];
                        rx_last[g][n_rx[g] % 16] = m_tlast[g];
                        n_rx[g] = n_rx[g] + 1;
                    end
                end
            end
        end
    end

    task automatic spi_bit(input int m, input logic b, output logic mb);
        logic cpol, cpha;
        cpol = 1'(m >> 1);
        cpha = 1'(m);
        if (!cpha) begin
            mosi[m] = b;
            repeat (HALF) @(negedge clk);
            mb = miso[m];
            sclk[m] = ~cpol;
            repeat (HALF) @(negedge clk);
            sclk[m] = cpol;
        end else begin
            sclk[m] = ~cpol;
            mosi[m] = b;
            repeat (HALF) @(negedge clk);
            mb = miso[m];
            sclk[m] = cpol;
            repeat (HALF) @(negedge clk);
        end
    endtask

    // Full frame of nwords words from f_mosi, plus an optional partial word of tail bits.
    task automatic spi_frame(input int m, input int nwords, input int tail);
        logic       b;
        logic [7:0] w;
        int         nb;
        s_tdata[m] = f_tx[0];
        cs[m] = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int wi = 0; wi < nwords + ((tail > 0) ? 1 : 0); wi++) begin
            nb = (wi < nwords) ? 8 : tail;
            w  = 8'h00;
            for (int bi = 0; bi < nb; bi++) begin
                spi_bit(m, f_mosi[wi][7-bi], b);
                w = {w[6:0], b};
                if (bi == 3) s_tdata[m] = f_tx[wi+1];
            end
            f_miso[wi] = w;
        end
        repeat (HALF) @(negedge clk);
        cs[m] = 1'b1;
        repeat (3 * HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (miso !== 4'h0) begin errors++; $display("FAIL rst_miso got=%b exp=0000", miso); end
        checks++; if (m_tvalid !== 4'h0) begin errors++; $display("FAIL rst_tvalid got=%b exp=0000", m_tvalid); end
        checks++; if (m_tlast !== 4'h0) begin errors++; $display("FAIL rst_tlast got=%b exp=0000", m_tlast); end
        checks++; if (s_tready !== 4'h0) begin errors++; $display("FAIL rst_tready got=%b exp=0000", s_tready); end
        checks++; if ({underrun, overrun, frame_err} !== 12'h000) begin errors++; $display("FAIL rst_flags got=%h exp=000", {underrun, overrun, frame_err}); end
        checks++; if (m_tdata[0] !== 8'h00 || m_tdata[3] !== 8'h00) begin errors++; $display("FAIL rst_tdata got=%h/%h exp=00/00", m_tdata[0], m_tdata[3]); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_mode0_basic();
        int b_rx, b_sh, b_un;
        b_rx = n_rx[0]; b_sh = n_shs[0]; b_un = n_under[0];
        f_mosi[0] = 8'hA5; f_tx[0] = 8'h3C; f_tx[1] = 8'h00;
        spi_frame(0, 1, 0);
        checks++; if (f_miso[0] !== 8'h3C) begin errors++; $display("FAIL m0_miso got=%h exp=3c", f_miso[0]); end
        checks++; if (n_rx[0] - b_rx !== 1) begin errors++; $display("FAIL m0_beats got=%0d exp=1", n_rx[0] - b_rx); end
        checks++; if (rx_data[0][b_rx % 16] !== 8'hA5 || rx_last[0][b_rx % 16] !== 1'b1) begin errors++; $display("FAIL m0_rx got=%h/%b exp=a5/1", rx_data[0][b_rx % 16], rx_last[0][b_rx % 16]); end
        // One load at CS fall, one more after the single word completes.
        checks++; if (n_shs[0] - b_sh !== 2) begin errors++; $display("FAIL m0_handshakes got=%0d exp=2", n_shs[0] - b_sh); end
        checks++; if (n_under[0] - b_un !== 0) begin errors++; $display("FAIL m0_underrun got=%0d exp=0", n_under[0] - b_un); end
    endtask

    task automatic test_mode3_two_words();
        int b_rx, b_fl;
        b_rx = n_rx[3]; b_fl = n_under[3] + n_over[3] + n_ferr[3];
        f_mosi[0] = 8'h12; f_mosi[1] = 8'h34;
        f_tx[0] = 8'hF0; f_tx[1] = 8'h0F; f_tx[2] = 8'h00;
        spi_frame(3, 2, 0);
        checks++; if (f_miso[0] !== 8'hF0 || f_miso[1] !== 8'h0F) begin errors++; $display("FAIL m3_miso got=%h,%h exp=f0,0f", f_miso[0], f_miso[1]); end
        checks++; if (n_rx[3] - b_rx !== 2) begin errors++; $display("FAIL m3_beats got=%0d exp=2", n_rx[3] - b_rx); end
        checks++; if (rx_data[3][b_rx % 16] !== 8'h12 || rx_last[3][b_rx % 16] !== 1'b0) begin errors++; $display("FAIL m3_rx0 got=%h/%b exp=12/0", rx_data[3][b_rx % 16], rx_last[3][b_rx % 16]); end
        checks++; if (rx_data[3][(b_rx + 1) % 16] !== 8'h34 || rx_last[3][(b_rx + 1) % 16] !== 1'b1) begin errors++; $display("FAIL m3_rx1 got=%h/%b exp=34/1", rx_data[3][(b_rx + 1) % 16], rx_last[3][(b_rx + 1) % 16]); end
        checks++; if (n_under[3] + n_over[3] + n_ferr[3] - b_fl !== 0) begin errors++; $display("FAIL m3_flags got=%0d exp=0", n_under[3] + n_over[3] + n_ferr[3] - b_fl); end
    endtask

    task automatic test_mode1_underrun();
        int b_rx, b_un;
        b_rx = n_rx[1]; b_un = n_under[1];
        f_mosi[0] = 8'h55; f_tx[0] = 8'h00; f_tx[1] = 8'h00;
        s_tvalid[1] = 1'b0;
        fork
            spi_frame(1, 1, 0);
            begin
                repeat (30) @(negedge clk);
                s_tvalid[1] = 1'b1;
            end
        join
        checks++; if (f_miso[0] !== 8'h00) begin errors++; $display("FAIL m1_miso got=%h exp=00", f_miso[0]); end
        checks++; if (n_under[1] - b_un !== 1) begin errors++; $display("FAIL m1_underrun got=%0d exp=1", n_under[1] - b_un); end
        checks++; if (n_rx[1] - b_rx !== 1) begin errors++; $display("FAIL m1_beats got=%0d exp=1", n_rx[1] - b_rx); end
        checks++; if (rx_data[1][b_rx % 16] !== 8'h55 || rx_last[1][b_rx % 16] !== 1'b1) begin errors++; $display("FAIL m1_rx got=%h/%b exp=55/1", rx_data[1][b_rx % 16], rx_last[1][b_rx % 16]); end
    endtask

    task automatic test_mode2_overrun();
        int b_rx, b_ov;
        b_rx = n_rx[2]; b_ov = n_over[2];
        f_mosi[0] = 8'h01; f_mosi[1] = 8'h02; f_mosi[2] = 8'h03;
        m_tready[2] = 1'b0;
        spi_frame(2, 3, 0);
        checks++; if (n_over[2] - b_ov !== 2) begin errors++; $display("FAIL m2_overrun got=%0d exp=2", n_over[2] - b_ov); end
        checks++; if (n_rx[2] - b_rx !== 0) begin errors++; $display("FAIL m2_beats_held got=%0d exp=0", n_rx[2] - b_rx); end
        checks++; if (m_tvalid[2] !== 1'b1 || m_tdata[2] !== 8'h01 || m_tlast[2] !== 1'b0) begin errors++; $display("FAIL m2_hold got=%b/%h/%b exp=1/01/0", m_tvalid[2], m_tdata[2], m_tlast[2]); end
        m_tready[2] = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (n_rx[2] - b_rx !== 1) begin errors++; $display("FAIL m2_beats got=%0d exp=1", n_rx[2] - b_rx); end
        checks++; if (rx_data[2][b_rx % 16] !== 8'h01) begin errors++; $display("FAIL m2_rx got=%h exp=01", rx_data[2][b_rx % 16]); end
        checks++; if (m_tvalid[2] !== 1'b0) begin errors++; $display("FAIL m2_drained got=%b exp=0", m_tvalid[2]); end
    endtask

    task automatic test_frame_error();
        int b_rx, b_fe;
        b_rx = n_rx[0]; b_fe = n_ferr[0];
        f_mosi[0] = 8'h81; f_mosi[1] = 8'hFF;
        spi_frame(0, 1, 5);
        checks++; if (n_rx[0] - b_rx !== 1) begin errors++; $display("FAIL fe_beats got=%0d exp=1", n_rx[0] - b_rx); end
        checks++; if (rx_data[0][b_rx % 16] !== 8'h81) begin errors++; $display("FAIL fe_rx got=%h exp=81", rx_data[0][b_rx % 16]); end
        checks++; if (n_ferr[0] - b_fe !== 1) begin errors++; $display("FAIL fe_pulse got=%0d exp=1", n_ferr[0] - b_fe); end
        f_mosi[0] = 8'h7E;
        spi_frame(0, 1, 0);
        checks++; if (n_rx[0] - b_rx !== 2) begin errors++; $display("FAIL fe_next_beats got=%0d exp=2", n_rx[0] - b_rx); end
        checks++; if (rx_data[0][(b_rx + 1) % 16] !== 8'h7E || rx_last[0][(b_rx + 1) % 16] !== 1'b1) begin errors++; $display("FAIL fe_next_rx got=%h/%b exp=7e/1", rx_data[0][(b_rx + 1) % 16], rx_last[0][(b_rx + 1) % 16]); end
        checks++; if (n_ferr[0] - b_fe !== 1) begin errors++; $display("FAIL fe_clean got=%0d exp=1", n_ferr[0] - b_fe); end
    endtask

    task automatic test_reset_mid_word();
        int   b_rx, b_fe;
        logic b;
        b_rx = n_rx[0]; b_fe = n_ferr[0];
        s_tdata[0] = 8'hFF;
        cs[0] = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 3; i++) spi_bit(0, 1'b1, b);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (miso[0] !== 1'b0 || s_tready[0] !== 1'b0) begin errors++; $display("FAIL mr_pins got=%b/%b exp=0/0", miso[0], s_tready[0]); end
        checks++; if (m_tvalid[0] !== 1'b0 || m_tlast[0] !== 1'b0 || m_tdata[0] !== 8'h00) begin errors++; $display("FAIL mr_stream got=%b/%b/%h exp=0/0/00", m_tvalid[0], m_tlast[0], m_tdata[0]); end
        for (int i = 0; i < 5; i++) spi_bit(0, 1'b1, b);
        repeat (HALF) @(negedge clk);
        cs[0] = 1'b1;
        repeat (3 * HALF) @(negedge clk);
        checks++; if (n_rx[0] - b_rx !== 0 || n_ferr[0] - b_fe !== 0) begin errors++; $display("FAIL mr_ignored got=%0d/%0d exp=0/0", n_rx[0] - b_rx, n_ferr[0] - b_fe); end
        checks++; if (miso[0] !== 1'b0) begin errors++; $display("FAIL mr_miso_idle got=%b exp=0", miso[0]); end
        f_mosi[0] = 8'hC3; f_tx[0] = 8'h00;
        spi_frame(0, 1, 0);
        checks++; if (n_rx[0] - b_rx !== 1) begin errors++; $display("FAIL mr_beats got=%0d exp=1", n_rx[0] - b_rx); end
        checks++; if (rx_data[0][b_rx % 16] !== 8'hC3 || rx_last[0][b_rx % 16] !== 1'b1) begin errors++; $display("FAIL mr_rx got=%h/%b exp=c3/1", rx_data[0][b_rx % 16], rx_last[0][b_rx % 16]); end
    endtask

    initial begin
        test_reset();
        test_mode0_basic();
        test_mode3_two_words();
        test_mode1_underrun();
        test_mode2_overrun();
        test_frame_error();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
